// File: rtl/toy_bus_pkg.sv
// ToyBus request payload definitions shared by the dmem request path.
package toy_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 32;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned SB_W   = 32;

    localparam logic OPC_READ  = 1'b0;
    localparam logic OPC_WRITE = 1'b1;

    // 361-bit single-beat request
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
        logic              opcode;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
        logic [SB_W-1:0]   sideband;
    } toy_bus_req_t;

endpackage

// File: rtl/toy_bus_req_slice2.sv
// Two-entry registered valid/ready FIFO for ToyBus requests.
// space_o depends only on occupancy, so there is no pop->space combinational path.
module toy_bus_req_slice2
    import toy_bus_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  toy_bus_req_t push_data_i,
    output logic         space_o,
    input  logic         pop_i,
    output logic         vld_o,
    output toy_bus_req_t data_o
);

    toy_bus_req_t mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push;
    logic         pop;

    assign space_o = (cnt_q != 2'd2);
    assign vld_o   = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        push     = push_i && space_o;
        pop      = pop_i && vld_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage; zeroed on reset so out_* is never X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 2'd2);

endmodule

// File: rtl/toy_bus_arb_node_dmem_req_slice.sv
// 2:1 round-robin merge of dmem decoder requests into a 2-entry registered slice.
// rr_last_q==1 gives in0 priority; it records the index of the last accepted port.
module toy_bus_arb_node_dmem_req_slice
    import toy_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic [STRB_W-1:0] in0_strb,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_opcode,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    input  logic [SB_W-1:0]   in0_sideband,
    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic [STRB_W-1:0] in1_strb,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_opcode,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,
    input  logic [SB_W-1:0]   in1_sideband,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [ADDR_W-1:0] out_addr,
    output logic [STRB_W-1:0] out_strb,
    output logic [DATA_W-1:0] out_data,
    output logic              out_opcode,
    output logic [ID_W-1:0]   out_src_id,
    output logic [ID_W-1:0]   out_tgt_id,
    output logic [SB_W-1:0]   out_sideband
);

    toy_bus_req_t in0_req, in1_req, push_req, out_req;
    logic [1:0]   grant;
    logic         space;
    logic         push;
    logic         rr_last_q, rr_last_d;

    assign in0_req = '{addr: in0_addr, strb: in0_strb, data: in0_data, opcode: in0_opcode,
                       src_id: in0_src_id, tgt_id: in0_tgt_id, sideband: in0_sideband};
    assign in1_req = '{addr: in1_addr, strb: in1_strb, data: in1_data, opcode: in1_opcode,
                       src_id: in1_src_id, tgt_id: in1_tgt_id, sideband: in1_sideband};

    // Round-robin grant, then accept only when the slice has room and reset is released
    always_comb begin
        grant = 2'b00;
        if (rr_last_q) begin
            if (in0_vld)      grant = 2'b01;
            else if (in1_vld) grant = 2'b10;
        end else begin
            if (in1_vld)      grant = 2'b10;
            else if (in0_vld) grant = 2'b01;
        end
        in0_rdy   = grant[0] && space && rst_n;
        in1_rdy   = grant[1] && space && rst_n;
        push      = in0_rdy || in1_rdy;
        push_req  = grant[1] ? in1_req : in0_req;
        rr_last_d = rr_last_q;
        if (push) rr_last_d = grant[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last_q <= 1'b1;
        else        rr_last_q <= rr_last_d;
    end

    toy_bus_req_slice2 u_slice (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_req),
        .space_o     (space),
        .pop_i       (out_rdy),
        .vld_o       (out_vld),
        .data_o      (out_req)
    );

    assign out_addr     = out_req.addr;
    assign out_strb     = out_req.strb;
    assign out_data     = out_req.data;
    assign out_opcode   = out_req.opcode;
    assign out_src_id   = out_req.src_id;
    assign out_tgt_id   = out_req.tgt_id;
    assign out_sideband = out_req.sideband;

    a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0({in1_rdy, in0_rdy}));
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                   (out_vld && !out_rdy) |=> $stable(out_req));

endmodule
